// File: rtl/dram_cmd_sched_if.sv
// dram_cmd_sched_if: command intake (valid/ready) and DRAM four-phase handshake bundle
interface dram_cmd_sched_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  localparam int BW = NUM_OF_BANKS > 1 ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW = NUM_OF_ROWS > 1 ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CW = NUM_OF_COLS > 1 ? $clog2(NUM_OF_COLS) : 1;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_cmd;
  logic [BW-1:0]           in_bank;
  logic [RW-1:0]           in_row;
  logic [CW-1:0]           in_col;
  logic                    cmd_req;
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    cmd_ack;
  logic                    cmd_done;
  logic                    cmd_err;
  modport master (
    output in_valid, in_cmd, in_bank, in_row, in_col, cmd_ack,
    input  in_ready, cmd_req, cmd, bank_sel, row_sel, col_sel, cmd_done, cmd_err
  );
  modport slave (
    input  in_valid, in_cmd, in_bank, in_row, in_col, cmd_ack,
    output in_ready, cmd_req, cmd, bank_sel, row_sel, col_sel, cmd_done, cmd_err
  );
endinterface

// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: one-at-a-time DRAM command issue with tRCD/tRP/tRAS spacing and handshake timeout
// Optional per-bank open-row checking under `CMD_SCHED_BANK_CHECK_EN.
module dram_cmd_sched #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_RAS        = 6,
  parameter int HS_TIMEOUT   = 15
) (
  input logic             clk,
  input logic             rst_b,
  dram_cmd_sched_if.slave bus
);
  localparam int BW = NUM_OF_BANKS > 1 ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW = NUM_OF_ROWS > 1 ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CW = NUM_OF_COLS > 1 ? $clog2(NUM_OF_COLS) : 1;
  localparam logic [7:0] RCD = 8'(T_RCD);
  localparam logic [7:0] RP  = 8'(T_RP);
  localparam logic [7:0] RAS = 8'(T_RAS);
  localparam logic [7:0] HST = 8'(HS_TIMEOUT - 1);
  localparam logic [1:0] ACT = 2'b00;
  localparam logic [1:0] PRE = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, REQ, RELEASE} state_t;
  state_t        state;
  logic [1:0]    lat_cmd;
  logic [BW-1:0] lat_bank;
  logic [RW-1:0] lat_row;
  logic [CW-1:0] lat_col;
  logic [7:0]    act_cnt, pre_cnt, hs_cnt;
  logic          timing_ok, bank_bad, done_evt;
  always_comb timing_ok = lat_cmd == ACT ? pre_cnt >= RP : lat_cmd == PRE ? act_cnt >= RAS : act_cnt >= RCD;
  always_comb done_evt = state == RELEASE && !bus.cmd_ack;
`ifdef CMD_SCHED_BANK_CHECK_EN
  logic [NUM_OF_BANKS-1:0] open_flag;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];
  always_comb bank_bad = bus.in_cmd == ACT ? open_flag[bus.in_bank] :
                         bus.in_cmd != PRE && (!open_flag[bus.in_bank] || open_row[bus.in_bank] != bus.in_row);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) open_flag <= '0;
    else if (done_evt && (lat_cmd == ACT || lat_cmd == PRE)) open_flag[lat_bank] <= lat_cmd == ACT;
  always_ff @(posedge clk)
    if (done_evt && lat_cmd == ACT) open_row[lat_bank] <= lat_row;
`else
  always_comb bank_bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      bus.in_ready <= 1'b1;
      bus.cmd_req  <= 1'b0;
      bus.cmd      <= '0;
      bus.bank_sel <= '0;
      bus.row_sel  <= '0;
      bus.col_sel  <= '0;
      bus.cmd_done <= 1'b0;
      bus.cmd_err  <= 1'b0;
      lat_cmd      <= '0;
      lat_bank     <= '0;
      lat_row      <= '0;
      lat_col      <= '0;
      act_cnt      <= 8'hff;
      pre_cnt      <= 8'hff;
      hs_cnt       <= '0;
    end else begin
      bus.cmd_done <= 1'b0;
      bus.cmd_err  <= 1'b0;
      act_cnt      <= act_cnt + {7'd0, act_cnt != 8'hff};
      pre_cnt      <= pre_cnt + {7'd0, pre_cnt != 8'hff};
      hs_cnt       <= hs_cnt + 8'd1;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_ready && bus.in_valid) begin
            lat_cmd      <= bus.in_cmd;
            lat_bank     <= bus.in_bank;
            lat_row      <= bus.in_row;
            lat_col      <= bus.in_col;
            bus.in_ready <= 1'b0;
            bus.cmd_err  <= bank_bad;
            state        <= bank_bad ? IDLE : WAIT;
          end
        end
        WAIT: if (timing_ok) begin
          state        <= REQ;
          bus.cmd_req  <= 1'b1;
          hs_cnt       <= '0;
          bus.cmd      <= lat_cmd;
          bus.bank_sel <= NUM_OF_BANKS'(1) << lat_bank;
          bus.row_sel  <= NUM_OF_ROWS'(1) << lat_row;
          bus.col_sel  <= NUM_OF_COLS'(1) << lat_col;
        end
        REQ: begin
          if (bus.cmd_ack) begin
            state       <= RELEASE;
            bus.cmd_req <= 1'b0;
            hs_cnt      <= '0;
          end else if (hs_cnt == HST) begin
            state        <= IDLE;
            bus.cmd_req  <= 1'b0;
            bus.cmd_err  <= 1'b1;
            bus.cmd      <= '0;
            bus.bank_sel <= '0;
            bus.row_sel  <= '0;
            bus.col_sel  <= '0;
          end
        end
        default: begin
          if (!bus.cmd_ack || hs_cnt == HST) begin
            state        <= IDLE;
            bus.cmd_done <= !bus.cmd_ack;
            bus.cmd_err  <= bus.cmd_ack;
            bus.cmd      <= '0;
            bus.bank_sel <= '0;
            bus.row_sel  <= '0;
            bus.col_sel  <= '0;
          end
          if (!bus.cmd_ack && lat_cmd == ACT) act_cnt <= '0;
          if (!bus.cmd_ack && lat_cmd == PRE) pre_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb_dram_cmd_sched: scoreboard bench for dram_cmd_sched with a one-cycle-lag ack responder
module tb_dram_cmd_sched;
  localparam int NB = 8, NR = 128, NC = 8;
  localparam int T_RCD = 3, T_RP = 3, T_RAS = 6, HS_TIMEOUT = 15;
  typedef struct {
    logic [1:0] cmd;
    int bank, row, col, acc, kind;
  } exp_t;
  logic clk = 0, rst_b = 0;
  logic ack_en = 1, req_d = 0, err_prev = 0, prev_req = 0;
  int cyc = 0, req_cyc = -1, last_act = -1000, last_pre = -1000;
  int checks = 0, failures = 0;
  exp_t q[$];
  dram_cmd_sched_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();
  dram_cmd_sched #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .HS_TIMEOUT(HS_TIMEOUT)
  ) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  initial forever begin
    @(negedge clk);
    bus.cmd_ack = ack_en ? req_d : 1'b0;
    req_d = bus.cmd_req;
  end
  always @(negedge clk) begin
    if (!rst_b) begin
      prev_req = 0;
      err_prev = 0;
    end else begin
      exp_t e;
      logic [NB-1:0] eb;
      logic [NR-1:0] er;
      logic [NC-1:0] ec;
      int t;
      if (err_prev) chk("ready_after_err", bus.in_ready, 1);
      err_prev = 0;
      if (bus.cmd_done) chk("ready_in_done", bus.in_ready, 0);
      if (bus.cmd_req && !prev_req) begin
        if (q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          e = q[0];
          eb = '0; er = '0; ec = '0;
          eb[e.bank] = 1'b1; er[e.row] = 1'b1; ec[e.col] = 1'b1;
          chk("cmd", bus.cmd, e.cmd);
          chk("bank_sel", bus.bank_sel, eb);
          chk("row_sel", bus.row_sel, er);
          if (e.cmd == 2'b01 || e.cmd == 2'b10) chk("col_sel", bus.col_sel, ec);
          t = e.cmd == 2'b00 ? last_pre + T_RP + 1 : e.cmd == 2'b11 ? last_act + T_RAS + 1 : last_act + T_RCD + 1;
          if (t < e.acc + 2) t = e.acc + 2;
          chk("req_time", cyc, t);
          req_cyc = cyc;
        end
      end
      if (bus.cmd_done || bus.cmd_err) begin
        if (q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = q.pop_front();
          chk("outcome", bus.cmd_done ? 0 : 1, e.kind == 0 ? 0 : 1);
          if (bus.cmd_done) begin
            chk("done_lat", cyc - req_cyc, 4);
            if (e.cmd == 2'b00) last_act = cyc;
            if (e.cmd == 2'b11) last_pre = cyc;
          end else begin
            err_prev = 1;
            chk("err_req_low", bus.cmd_req, 0);
            if (e.kind == 1) chk("timeout_lat", cyc - req_cyc, HS_TIMEOUT);
            else begin
              chk("bank_err_lat", cyc - e.acc, 1);
              chk("bank_err_noreq", req_cyc >= e.acc, 0);
            end
          end
        end
      end
      prev_req = bus.cmd_req;
    end
  end
  task automatic send(input logic [1:0] c, input int b, input int r, input int co, input int k);
    exp_t e;
    int n = 0;
    @(negedge clk);
    bus.in_cmd = c; bus.in_bank = b[2:0]; bus.in_row = r[6:0]; bus.in_col = co[2:0];
    bus.in_valid = 1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    e.cmd = c; e.bank = b; e.row = r; e.col = co; e.acc = cyc; e.kind = k;
    q.push_back(e);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cmd_req", bus.cmd_req, 0);
    chk("rst_sels", {bus.bank_sel, bus.row_sel, bus.col_sel, bus.cmd}, 0);
    chk("rst_pulses", {bus.cmd_done, bus.cmd_err}, 0);
    last_act = -1000; last_pre = -1000; req_cyc = -1;
    q.delete();
    rst_b = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.in_valid = 0; bus.in_cmd = 0; bus.in_bank = 0; bus.in_row = 0; bus.in_col = 0; bus.cmd_ack = 0;
    do_reset();
    send(2'b00, 3, 5, 0, 0);
    send(2'b01, 3, 5, 2, 0);
    send(2'b11, 3, 5, 0, 0);
    send(2'b00, 3, 5, 0, 0);
    send(2'b10, 3, 5, 7, 0);
    send(2'b11, 3, 0, 0, 0);
    drain();
    ack_en = 0;
    send(2'b00, 0, 9, 0, 1);
    drain();
    ack_en = 1;
    send(2'b00, 7, 127, 0, 0);
    send(2'b01, 7, 127, 0, 0);
    send(2'b11, 7, 127, 0, 0);
    drain();
    do_reset();
`ifdef CMD_SCHED_BANK_CHECK_EN
    send(2'b01, 2, 0, 1, 2);
    drain();
    send(2'b00, 4, 10, 0, 0);
    send(2'b00, 4, 11, 0, 2);
    send(2'b10, 4, 12, 3, 2);
    drain();
`else
    send(2'b01, 2, 0, 1, 0);
    drain();
`endif
    ack_en = 0;
    send(2'b00, 1, 1, 0, 1);
    n = 0;
    while (!bus.cmd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midop_req_seen", bus.cmd_req, 1);
    rst_b = 0;
    #1;
    chk("midop_async_drop", bus.cmd_req, 0);
    do_reset();
    ack_en = 1;
    send(2'b00, 6, 3, 0, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
